rv64g_operand_fetch: RTL
========================

Name: rv64g_operand_fetch

Overview:
- Issue/operand-fetch stage directly upstream of the register file. Accepts one decoded instruction per cycle over a valid/ready handshake.
- Holds the instruction until every used source register and the destination register are unlocked in the register file. It then captures operands and locks the destination in the same cycle.
- Presents the instruction plus operands to the execute stage over a second valid/ready handshake.

Parameters:
- NR, rv64g_pkg::NUM_REGS, number of architectural registers (localparam).
- DW, rv64g_pkg::XLEN, operand width (localparam).
- AW, $clog2(NR), register address width (localparam).
- PW, 64, width of opaque decoded-control payload passed through unchanged.
- CW, 32, width of hazard stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  synchronous kill of all held instructions.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept this cycle.
- pl_i  in  PW  decoded control payload.
- rd_addr_i  in  AW  destination register.
- rd_wr_i  in  1  instruction writes rd.
- rs1_addr_i / rs2_addr_i / rs3_addr_i  in  AW each  source registers.
- rs1_use_i / rs2_use_i / rs3_use_i  in  1 each  source actually read.
- locks_i  in  NR  register-file lock vector; 1 = pending write. Same-cycle, includes the writeback bypass.
- rf_rs1_addr_o / rf_rs2_addr_o / rf_rs3_addr_o  out  AW each  read addresses to the register file.
- rf_rs1_data_i / rf_rs2_data_i / rf_rs3_data_i  in  DW each  read data; valid when the matching lock bit is 0.
- wr_lock_en_o  out  1  lock request to the register file.
- wr_lock_addr_o  out  AW  register to lock.
- valid_o  out  1  output instruction valid.
- ready_i  in  1  execute stage accepts.
- pl_o  out  PW  payload.
- rd_addr_o  out  AW  destination.
- rd_wr_o  out  1  writes rd.
- rs1_data_o / rs2_data_o / rs3_data_o  out  DW each  captured operands.
- stall_cnt_o  out  CW  saturating count of hazard-stall cycles.

Behaviour:
- Reset (arst_ni low, asynchronous):
  - H_valid=0, valid_o=0, all data outputs 0, stall_cnt_o=0.
  - ready_o=1 and wr_lock_en_o=0 whenever H is empty.
  - While in reset, locks_i reads all-ones; no issue can occur.
- Storage: a holding register H (one entry) and an output register O (one entry).
- Accept: valid_i & ready_o at a rising edge loads H.
- rf_rsN_addr_o is driven combinationally from H, or 0 when H is empty.
- Hazard condition:
  - hz = H_valid & ( OR over N of (rsN_use & locks_i[rsN_addr]) | (rd_wr & rd_addr!=0 & locks_i[rd_addr]) ).
  - Register 0 never causes a hazard; its lock bit is treated as 0.
  - An unused source never causes a hazard, whatever its address.
- Issue (fire):
  - fire = H_valid & ~hz & ~flush_i & (~valid_o | ready_i).
  - On fire: O <= {H fields, rf_rsN_data_i}.
  - wr_lock_en_o = fire & rd_wr & (rd_addr!=0), combinationally in the same cycle; wr_lock_addr_o = H rd_addr.
  - An unused rsN_data_o is captured as-is (don't-care for execute, but deterministic).
- ready_o = ~H_valid | fire. Throughput is 1 instruction/cycle with no hazards.
- Latency: accepted at edge k; at earliest valid_o=1 after edge k+1.
- Output hold: while valid_o & ~ready_i, O is stable and no fire occurs. At an edge with ready_i & ~fire, valid_o<=0.
- Lock/unlock collision: if writeback unlocks register X in the same cycle this stage locks X, the register file's lock takes precedence. That is the required outcome: the new writer owns X.
- flush_i (sync, highest priority):
  - Next edge sets H_valid=0 and valid_o=0.
  - A valid_i arriving in the flush cycle is dropped.
  - wr_lock_en_o=0 during flush.
  - stall_cnt_o is unaffected.
- stall_cnt_o increments by 1 each cycle with hz=1 and ~flush_i, and saturates at all-ones; it has no wrap.
- Reset mid-operation: H and O contents are discarded; no lock is issued.

Test Plan:
- No hazards: back-to-back add x3←x1,x2 then x4←x5,x6 with locks_i=0 -> valid_o on consecutive cycles, 2-cycle latency, wr_lock_en_o pulses addr 3 then 4, ready_o stays 1.
- RAW stall: rs1=7 used, locks_i[7]=1 for 3 cycles, then clears with rf_rs1_data_i=0xDEAD_BEEF -> ready_o=0 for 3 cycles, rs1_data_o=0xDEADBEEF, stall_cnt_o=3.
- x0 and unused sources: rd=0, rs2=9 unused, locks_i[9]=1 and locks_i[0]=1 -> issues without stall, wr_lock_en_o=0.
- Back-pressure: ready_i=0 for 4 cycles with 2 instructions sent -> O holds the first instruction unchanged, H holds the second, ready_o=0, no second lock pulse until ready_i=1.
- WAW: rd=5 with locks_i[5]=1 -> stall until cleared, then wr_lock_en_o with addr 5 in the issue cycle.
- Flush: flush_i during a hazard stall with an O valid -> next cycle valid_o=0, H empty, ready_o=1, no lock pulse. A reset asserted mid-stall gives all outputs 0.

Source files
------------

// File: rtl/rv64g_pkg.sv
// Core-wide architectural constants for the RV64G pipeline.
package rv64g_pkg;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 64;
endpackage

// File: rtl/rv64g_operand_fetch.sv
// Operand-fetch / issue stage. One holding entry waits for the register
// file to report every used source and the destination as unlocked, then
// captures the operands, locks the destination and hands the instruction
// to execute through a one-entry output register.
module rv64g_operand_fetch
    import rv64g_pkg::*;
#(
    parameter  int PW = 64,
    parameter  int CW = 32,
    localparam int NR = NUM_REGS,
    localparam int DW = XLEN,
    localparam int AW = $clog2(NR)
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [PW-1:0] pl_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_wr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic [AW-1:0] rs3_addr_i,
    input  logic          rs1_use_i,
    input  logic          rs2_use_i,
    input  logic          rs3_use_i,
    input  logic [NR-1:0] locks_i,
    output logic [AW-1:0] rf_rs1_addr_o,
    output logic [AW-1:0] rf_rs2_addr_o,
    output logic [AW-1:0] rf_rs3_addr_o,
    input  logic [DW-1:0] rf_rs1_data_i,
    input  logic [DW-1:0] rf_rs2_data_i,
    input  logic [DW-1:0] rf_rs3_data_i,
    output logic          wr_lock_en_o,
    output logic [AW-1:0] wr_lock_addr_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [PW-1:0] pl_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_wr_o,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    output logic [DW-1:0] rs3_data_o,
    output logic [CW-1:0] stall_cnt_o
);

    // Stage p0: holding register H
    logic          r_vld_p0;
    logic [PW-1:0] r_pl_p0;
    logic [AW-1:0] r_rd_p0;
    logic          r_rd_wr_p0;
    logic [AW-1:0] r_rs1_p0;
    logic [AW-1:0] r_rs2_p0;
    logic [AW-1:0] r_rs3_p0;
    logic          r_use1_p0;
    logic          r_use2_p0;
    logic          r_use3_p0;

    // Stage p1: output register O
    logic          r_vld_p1;
    logic [PW-1:0] r_pl_p1;
    logic [AW-1:0] r_rd_p1;
    logic          r_rd_wr_p1;
    logic [DW-1:0] r_rs1_data_p1;
    logic [DW-1:0] r_rs2_data_p1;
    logic [DW-1:0] r_rs3_data_p1;

    logic [CW-1:0] r_stall_cnt;

    logic w_lock_rs1;
    logic w_lock_rs2;
    logic w_lock_rs3;
    logic w_lock_rd;
    logic w_hz;
    logic w_fire;
    logic w_accept;
    logic w_rd_nz;

    // x0 is never locked, and an unused source is never waited on.
    assign w_lock_rs1 = r_use1_p0 & (r_rs1_p0 != '0) & locks_i[r_rs1_p0];
    assign w_lock_rs2 = r_use2_p0 & (r_rs2_p0 != '0) & locks_i[r_rs2_p0];
    assign w_lock_rs3 = r_use3_p0 & (r_rs3_p0 != '0) & locks_i[r_rs3_p0];
    assign w_rd_nz    = (r_rd_p0 != '0);
    assign w_lock_rd  = r_rd_wr_p0 & w_rd_nz & locks_i[r_rd_p0];

    assign w_hz     = r_vld_p0 & (w_lock_rs1 | w_lock_rs2 | w_lock_rs3 | w_lock_rd);
    assign w_fire   = r_vld_p0 & ~w_hz & ~flush_i & (~r_vld_p1 | ready_i);
    assign w_accept = valid_i & ready_o & ~flush_i;

    assign ready_o = ~r_vld_p0 | w_fire;

    assign rf_rs1_addr_o = r_vld_p0 ? r_rs1_p0 : '0;
    assign rf_rs2_addr_o = r_vld_p0 ? r_rs2_p0 : '0;
    assign rf_rs3_addr_o = r_vld_p0 ? r_rs3_p0 : '0;

    // The lock goes out in the issue cycle so the next instruction already sees it.
    assign wr_lock_en_o   = w_fire & r_rd_wr_p0 & w_rd_nz;
    assign wr_lock_addr_o = r_rd_p0;

    assign valid_o     = r_vld_p1;
    assign pl_o        = r_pl_p1;
    assign rd_addr_o   = r_rd_p1;
    assign rd_wr_o     = r_rd_wr_p1;
    assign rs1_data_o  = r_rs1_data_p1;
    assign rs2_data_o  = r_rs2_data_p1;
    assign rs3_data_o  = r_rs3_data_p1;
    assign stall_cnt_o = r_stall_cnt;

    // Holding register: flush kills it, accept loads it, issue empties it.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_vld_p0   <= 1'b0;
            r_pl_p0    <= '0;
            r_rd_p0    <= '0;
            r_rd_wr_p0 <= 1'b0;
            r_rs1_p0   <= '0;
            r_rs2_p0   <= '0;
            r_rs3_p0   <= '0;
            r_use1_p0  <= 1'b0;
            r_use2_p0  <= 1'b0;
            r_use3_p0  <= 1'b0;
        end else if (flush_i) begin
            r_vld_p0 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p0   <= 1'b1;
            r_pl_p0    <= pl_i;
            r_rd_p0    <= rd_addr_i;
            r_rd_wr_p0 <= rd_wr_i;
            r_rs1_p0   <= rs1_addr_i;
            r_rs2_p0   <= rs2_addr_i;
            r_rs3_p0   <= rs3_addr_i;
            r_use1_p0  <= rs1_use_i;
            r_use2_p0  <= rs2_use_i;
            r_use3_p0  <= rs3_use_i;
        end else if (w_fire) begin
            r_vld_p0 <= 1'b0;
        end
    end

    // Output register: captures operands on issue, drains when execute takes it.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_vld_p1      <= 1'b0;
            r_pl_p1       <= '0;
            r_rd_p1       <= '0;
            r_rd_wr_p1    <= 1'b0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_rs3_data_p1 <= '0;
        end else if (flush_i) begin
            r_vld_p1 <= 1'b0;
        end else if (w_fire) begin
            r_vld_p1      <= 1'b1;
            r_pl_p1       <= r_pl_p0;
            r_rd_p1       <= r_rd_p0;
            r_rd_wr_p1    <= r_rd_wr_p0;
            r_rs1_data_p1 <= rf_rs1_data_i;
            r_rs2_data_p1 <= rf_rs2_data_i;
            r_rs3_data_p1 <= rf_rs3_data_i;
        end else if (ready_i) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // Hazard-stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_hz && !flush_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

endmodule
